// File: rtl/exec_cc_stage.sv
// Y86-64 execute-stage back end: condition codes, branch/cmov condition and the E->M register.
// e_cnd depends only on the registered CC and E_ifun, never on alu_out.
module exec_cc_stage #(
    parameter int unsigned W       = 64,
    parameter logic [3:0]  RNONE   = 4'hF,
    parameter logic [3:0]  INOP    = 4'h1,
    parameter logic [3:0]  IOPQ    = 4'h6,
    parameter logic [3:0]  IRRMOVQ = 4'h2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         E_valid,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [2:0]   E_stat,
    input  logic [W-1:0] E_valA,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [W-1:0] alu_out,
    input  logic         alu_ovf,
    input  logic         exc_block,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of,
    output logic         e_cnd,
    output logic         M_valid,
    output logic [3:0]   M_icode,
    output logic [3:0]   M_ifun,
    output logic [2:0]   M_stat,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    localparam logic [2:0] StatAok = 3'd1;

    logic         zf_q, sf_q, of_q;
    logic         cond;
    logic         lt;
    logic [3:0]   e_dstE;
    logic         cc_en;

    logic         valid_q;
    logic [3:0]   icode_q, ifun_q, dste_q, dstm_q;
    logic [2:0]   stat_q;
    logic         cnd_q;
    logic [W-1:0] vale_q, vala_q;

    assign lt = sf_q ^ of_q;

    always_comb begin
        cond = 1'b0;
        case (E_ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = lt | zf_q;
            4'd2:    cond = lt;
            4'd3:    cond = zf_q;
            4'd4:    cond = ~zf_q;
            4'd5:    cond = ~lt;
            4'd6:    cond = ~lt & ~zf_q;
            default: cond = 1'b0;
        endcase
    end

    assign e_cnd  = cond;
    // A cmov whose condition fails must not write its destination.
    assign e_dstE = (E_icode == IRRMOVQ && !cond) ? RNONE : E_dstE;
    assign cc_en  = E_valid & (E_icode == IOPQ) & ~exc_block & ~M_stall & ~reset
                  & (E_stat == StatAok);

    always_ff @(posedge clk) begin
        if (reset) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (cc_en) begin
            zf_q <= (alu_out == '0);
            sf_q <= alu_out[W-1];
            of_q <= alu_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (!M_stall && M_bubble)) begin
            valid_q <= 1'b0;
            icode_q <= INOP;
            ifun_q  <= 4'd0;
            stat_q  <= StatAok;
            cnd_q   <= 1'b0;
            vale_q  <= '0;
            vala_q  <= '0;
            dste_q  <= RNONE;
            dstm_q  <= RNONE;
        end else if (!M_stall) begin
            valid_q <= E_valid;
            icode_q <= E_icode;
            ifun_q  <= E_ifun;
            stat_q  <= E_stat;
            cnd_q   <= cond;
            vale_q  <= alu_out;
            vala_q  <= E_valA;
            dste_q  <= e_dstE;
            dstm_q  <= E_dstM;
        end
    end

    assign cc_zf   = zf_q;
    assign cc_sf   = sf_q;
    assign cc_of   = of_q;
    assign M_valid = valid_q;
    assign M_icode = icode_q;
    assign M_ifun  = ifun_q;
    assign M_stat  = stat_q;
    assign M_cnd   = cnd_q;
    assign M_valE  = vale_q;
    assign M_valA  = vala_q;
    assign M_dstE  = dste_q;
    assign M_dstM  = dstm_q;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Bench for exec_cc_stage: directed test-plan steps followed by random traffic,
// all checked against a behavioural model of the CC and E->M register.
module tb_exec_cc_stage;

    logic        clk = 1'b0;
    logic        reset, E_valid, alu_ovf, exc_block, M_stall, M_bubble;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
    logic [2:0]  E_stat;
    logic [63:0] E_valA, alu_out;
    logic        cc_zf, cc_sf, cc_of, e_cnd;
    logic        M_valid, M_cnd;
    logic [3:0]  M_icode, M_ifun, M_dstE, M_dstM;
    logic [2:0]  M_stat;
    logic [63:0] M_valE, M_valA;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    // Reference model state
    bit          mzf, msf, mof;
    bit          x_valid, x_cnd;
    bit [3:0]    x_icode, x_ifun, x_dstE, x_dstM;
    bit [2:0]    x_stat;
    bit [63:0]   x_valE, x_valA;

    always #5 clk = ~clk;

    exec_cc_stage dut (
        .clk(clk), .reset(reset), .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_stat(E_stat), .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .alu_out(alu_out), .alu_ovf(alu_ovf), .exc_block(exc_block), .M_stall(M_stall),
        .M_bubble(M_bubble), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .e_cnd(e_cnd),
        .M_valid(M_valid), .M_icode(M_icode), .M_ifun(M_ifun), .M_stat(M_stat),
        .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_cond(input bit [3:0] fn);
        bit less;
        less = (msf != mof);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return less || mzf;
            4'd2:    return less;
            4'd3:    return mzf;
            4'd4:    return !mzf;
            4'd5:    return !less;
            4'd6:    return !less && !mzf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_bubble();
        x_valid = 0; x_icode = 4'h1; x_ifun = 0; x_stat = 3'd1; x_cnd = 0;
        x_valE = 0;  x_valA = 0;     x_dstE = 4'hF; x_dstM = 4'hF;
    endtask

    task automatic model_step();
        bit c;
        c = model_cond(E_ifun);
        if (reset) begin
            mzf = 1; msf = 0; mof = 0;
            model_bubble();
        end else if (!M_stall) begin
            if (M_bubble) model_bubble();
            else begin
                x_valid = E_valid; x_icode = E_icode; x_ifun = E_ifun; x_stat = E_stat;
                x_cnd = c; x_valE = alu_out; x_valA = E_valA; x_dstM = E_dstM;
                x_dstE = (E_icode == 4'h2 && !c) ? 4'hF : E_dstE;
            end
            if (E_valid && E_icode == 4'h6 && !exc_block && E_stat == 3'd1) begin
                mzf = (alu_out == 64'd0);
                msf = (alu_out >= 64'h8000_0000_0000_0000);
                mof = alu_ovf;
            end
        end
    endtask

    // Apply current inputs for one clock, checking e_cnd before and all state after.
    task automatic cycle();
        #1;
        if (started) check("e_cnd", {63'd0, e_cnd}, {63'd0, model_cond(E_ifun)});
        model_step();
        @(posedge clk);
        #1;
        started = 1;
        check("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, mzf, msf, mof});
        check("M_valid", {63'd0, M_valid}, {63'd0, x_valid});
        check("M_icode", {60'd0, M_icode}, {60'd0, x_icode});
        check("M_ifun", {60'd0, M_ifun}, {60'd0, x_ifun});
        check("M_stat", {61'd0, M_stat}, {61'd0, x_stat});
        check("M_cnd", {63'd0, M_cnd}, {63'd0, x_cnd});
        check("M_valE", M_valE, x_valE);
        check("M_valA", M_valA, x_valA);
        check("M_dstE", {60'd0, M_dstE}, {60'd0, x_dstE});
        check("M_dstM", {60'd0, M_dstM}, {60'd0, x_dstM});
    endtask

    task automatic instr(input bit [3:0] ic, input bit [3:0] fn, input bit [63:0] res,
                         input bit ovf);
        reset = 0; E_valid = 1; E_icode = ic; E_ifun = fn; E_stat = 3'd1;
        alu_out = res; alu_ovf = ovf; exc_block = 0; M_stall = 0; M_bubble = 0;
        E_valA = res ^ 64'h5A5A; E_dstE = 4'd3; E_dstM = 4'hF;
    endtask

    initial begin
        instr(4'h1, 4'h0, 64'd0, 0);
        reset = 1;
        cycle();
        check("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
        check("rst_icode", {60'd0, M_icode}, 64'd1);
        check("rst_dstE", {60'd0, M_dstE}, 64'hF);
        check("rst_valid", {63'd0, M_valid}, 64'd0);
        check("rst_valE", M_valE, 64'd0);

        instr(4'h6, 4'h1, 64'd0, 0);                      // subq -> zero
        cycle();
        check("subq_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
        instr(4'h7, 4'h4, 64'd0, 0);                      // jne
        #1 check("jne_cnd", {63'd0, e_cnd}, 64'd0);
        cycle();
        check("jne_Mcnd", {63'd0, M_cnd}, 64'd0);

        instr(4'h6, 4'h1, 64'h8000_0000_0000_0000, 1);
        cycle();
        check("neg_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd3);
        instr(4'h7, 4'h2, 64'd0, 0);                      // jl
        #1 check("jl_cnd", {63'd0, e_cnd}, 64'd0);
        cycle();
        instr(4'h7, 4'h6, 64'd0, 0);                      // jg
        #1 check("jg_cnd", {63'd0, e_cnd}, 64'd1);
        cycle();

        instr(4'h6, 4'h0, 64'd1, 0);                      // cc = 000
        cycle();
        instr(4'h2, 4'h1, 64'd7, 0);                      // cmovle, fails
        cycle();
        check("cmov0_dstE", {60'd0, M_dstE}, 64'hF);
        check("cmov0_cnd", {63'd0, M_cnd}, 64'd0);
        instr(4'h6, 4'h1, 64'd0, 0);                      // ZF = 1
        cycle();
        instr(4'h2, 4'h1, 64'd7, 0);                      // cmovle, taken
        cycle();
        check("cmov1_dstE", {60'd0, M_dstE}, 64'd3);

        instr(4'h6, 4'h0, 64'd5, 0);
        exc_block = 1;
        cycle();
        check("exc_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
        check("exc_valE", M_valE, 64'd5);

        instr(4'h6, 4'h0, 64'd1, 0);                      // cc = 000, valE = 1
        cycle();
        instr(4'h6, 4'h1, 64'd0, 0);
        M_stall = 1; M_bubble = 1;
        cycle();
        check("stall_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd0);
        check("stall_valE", M_valE, 64'd1);
        check("stall_icode", {60'd0, M_icode}, 64'd6);
        instr(4'h6, 4'h1, 64'd0, 0);
        E_valid = 0; M_bubble = 1;
        cycle();
        check("bub_icode", {60'd0, M_icode}, 64'd1);
        check("bub_dstE", {60'd0, M_dstE}, 64'hF);
        check("bub_valid", {63'd0, M_valid}, 64'd0);
        check("bub_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       E_icode = 4'h6;
                1:       E_icode = 4'h2;
                2:       E_icode = 4'h7;
                default: E_icode = 4'($urandom_range(0, 15));
            endcase
            E_ifun    = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15))
                                                    : 4'($urandom_range(0, 6));
            E_valid   = ($urandom_range(0, 7) != 0);
            E_stat    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            case ($urandom_range(0, 3))
                0:       alu_out = 64'd0;
                1:       alu_out = {1'b1, 63'($urandom)};
                default: alu_out = {32'($urandom), 32'($urandom)};
            endcase
            alu_ovf   = 1'($urandom);
            E_valA    = {32'($urandom), 32'($urandom)};
            E_dstE    = 4'($urandom);
            E_dstM    = 4'($urandom);
            exc_block = ($urandom_range(0, 9) == 0);
            M_stall   = ($urandom_range(0, 9) == 0);
            M_bubble  = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
